store_checker: RTL

Synthesizable end-of-test checker for the pipelined RV32 core's data-memory write port. It snoops the store bus (`MemWrite`, `DataAdr`, `WriteData`) and classifies each store as a pass signature, a permitted scratch write, or an illegal write. It enforces a cycle timeout and latches a sticky verdict, which lets the same check run in simulation and on an FPGA. It generalises the fixed pass/fail store check into a parametrised block with a windowed scratch region, store/cycle counters, failure capture and an optional store trace.

---
 rtl/store_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/store_checker.sv
// End-of-test checker for the core's data-memory store bus: sticky PASS/FAIL verdict,
// scratch window, timeout, counters and failure capture. Optional store trace under `STORE_TRACE_EN.
module store_checker #(
  parameter int unsigned         ADDR_W       = 32,
  parameter int unsigned         DATA_W       = 32,
  parameter logic [ADDR_W-1:0]   PASS_ADDR    = ADDR_W'(100),
  parameter logic [DATA_W-1:0]   PASS_DATA    = DATA_W'(25),
  parameter logic [ADDR_W-1:0]   SCRATCH_BASE = ADDR_W'(96),
  parameter logic [ADDR_W-1:0]   SCRATCH_MASK = '0,
  parameter int unsigned         TIMEOUT      = 10000,
  parameter int unsigned         TRACE_DEPTH  = 4,
  localparam int unsigned        IDX_W        = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [15:0]       store_count,
  output logic [31:0]       cycle_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  input  logic [IDX_W-1:0]  trace_idx,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data
);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_PASS = 2'b01,
    S_FAIL = 2'b10
  } state_t;

  localparam logic [1:0]  CODE_ILLEGAL = 2'b01;
  localparam logic [1:0]  CODE_BADDATA = 2'b10;
  localparam logic [1:0]  CODE_TIMEOUT = 2'b11;
  localparam logic [31:0] TO_LAST      = (TIMEOUT == 0) ? '0 : 32'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [15:0]       store_count_q, store_count_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              store_ev;
  logic              scratch_hit;
  logic              timeout_hit;

  assign scratch_hit = ((DataAdr & ~SCRATCH_MASK) == SCRATCH_BASE);
  assign timeout_hit = (TIMEOUT != 0) && (cycle_count_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      fail_code_q   <= '0;
      store_count_q <= '0;
      cycle_count_q <= '0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    store_count_d = store_count_q;
    cycle_count_d = cycle_count_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    store_ev      = 1'b0;

    if (state_q == S_RUN) begin
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;

      if (MemWrite) begin
        store_ev = 1'b1;
        if (store_count_q != '1) store_count_d = store_count_q + 16'd1;

        // PASS_ADDR is decoded before the window so it may sit inside it
        if (DataAdr == PASS_ADDR) begin
          if (WriteData == PASS_DATA) begin
            state_d = S_PASS;
          end else begin
            state_d     = S_FAIL;
            fail_code_d = CODE_BADDATA;
            fail_addr_d = DataAdr;
            fail_data_d = WriteData;
          end
        end else if (!scratch_hit) begin
          state_d     = S_FAIL;
          fail_code_d = CODE_ILLEGAL;
          fail_addr_d = DataAdr;
          fail_data_d = WriteData;
        end
      end

      // a store-driven verdict in the last allowed cycle beats the timeout
      if ((state_d == S_RUN) && timeout_hit) begin
        state_d     = S_FAIL;
        fail_code_d = CODE_TIMEOUT;
        fail_addr_d = '0;
        fail_data_d = '0;
      end
    end
  end

  assign done        = (state_q != S_RUN);
  assign pass        = (state_q == S_PASS);
  assign fail_code   = fail_code_q;
  assign store_count = store_count_q;
  assign cycle_count = cycle_count_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

`ifdef STORE_TRACE_EN
  logic [ADDR_W-1:0] tr_addr_q [TRACE_DEPTH];
  logic [DATA_W-1:0] tr_data_q [TRACE_DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
        tr_addr_q[i] <= '0;
        tr_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (store_ev) begin
      tr_addr_q[wr_ptr_q] <= DataAdr;
      tr_data_q[wr_ptr_q] <= WriteData;
      wr_ptr_q            <= wr_ptr_q + IDX_W'(1);
    end
  end

  // newest entry sits one behind the write pointer; power-of-two depth wraps naturally
  assign rd_ptr     = wr_ptr_q - IDX_W'(1) - trace_idx;
  assign trace_addr = tr_addr_q[rd_ptr];
  assign trace_data = tr_data_q[rd_ptr];
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, store_ev};
  assign trace_addr   = '0;
  assign trace_data   = '0;
`endif

endmodule
